// File: rtl/raisin64_pkg.sv
// Shared Raisin64 constants used by the register file and its scoreboard.
package raisin64_pkg;

  localparam int unsigned RF_ADDR_W   = 6;
  localparam int unsigned RF_DATA_W   = 64;
  localparam int unsigned RF_ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on load issue, cleared on load return, set wins.
module regfile_scoreboard
  import raisin64_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_rn,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_rn,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [(1<<ADDR_W)-1:0]   busy_next
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_REG);

  always_comb begin
    busy_next = busy;
    if (clr_en && clr_rn != ZERO) busy_next[clr_rn] = 1'b0;
    if (set_en && set_rn != ZERO) busy_next[set_rn] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD registered write-first read ports, ALU (W0)
// and load-return (W1) write ports, and a busy scoreboard for pending loads.
module regfile_mp
  import raisin64_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NREAD  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREAD*ADDR_W-1:0]   r_rn,
  output logic [NREAD*DATA_W-1:0]   r_data,
  output logic [NREAD-1:0]          r_busy,
  input  logic                      w0_en,
  input  logic [ADDR_W-1:0]         w0_rn,
  input  logic [DATA_W-1:0]         w0_data,
  input  logic                      w1_en,
  input  logic [ADDR_W-1:0]         w1_rn,
  input  logic [DATA_W-1:0]         w1_data,
  input  logic                      set_en,
  input  logic [ADDR_W-1:0]         set_rn,
  output logic                      wr_conflict
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              w0_hit, w1_hit, set_hit;

  assign w0_hit  = w0_en  && (w0_rn  != ZERO);
  assign w1_hit  = w1_en  && (w1_rn  != ZERO);
  assign set_hit = set_en && (set_rn != ZERO);

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_rn    (set_rn),
    .clr_en    (w1_en),
    .clr_rn    (w1_rn),
    .busy      (busy),
    .busy_next (busy_next)
  );

  // W1 is written last so it wins a same-address collision with W0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (w0_hit) mem[w0_rn] <= w0_data;
      if (w1_hit) mem[w1_rn] <= w1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_conflict <= 1'b0;
    else        wr_conflict <= w0_hit && w1_hit && (w0_rn == w1_rn);
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [ADDR_W-1:0] rn;
    logic [DATA_W-1:0] data_d, data_q;
    logic              busy_d, busy_q;

    assign rn = r_rn[k*ADDR_W +: ADDR_W];

    // Forward this edge's writes and busy updates into the output register.
    always_comb begin
      data_d = mem[rn];
      busy_d = busy[rn];
      if (w0_hit && w0_rn == rn) data_d = w0_data;
      if (w1_hit && w1_rn == rn) data_d = w1_data;
      if ((w1_hit && w1_rn == rn) || (set_hit && set_rn == rn)) busy_d = busy_next[rn];
      if (rn == ZERO) begin
        data_d = '0;
        busy_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign r_data[k*DATA_W +: DATA_W] = data_q;
    assign r_busy[k]                  = busy_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with four read ports and hand-computed expectations.
module tb_regfile_mp;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 6;
  localparam int unsigned NR = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  r_rn;
  logic [NR*DW-1:0]  r_data;
  logic [NR-1:0]     r_busy;
  logic              w0_en, w1_en, set_en;
  logic [AW-1:0]     w0_rn, w1_rn, set_rn;
  logic [DW-1:0]     w0_data, w1_data;
  logic              wr_conflict;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .r_rn        (r_rn),
    .r_data      (r_data),
    .r_busy      (r_busy),
    .w0_en       (w0_en),
    .w0_rn       (w0_rn),
    .w0_data     (w0_data),
    .w1_en       (w1_en),
    .w1_rn       (w1_rn),
    .w1_data     (w1_data),
    .set_en      (set_en),
    .set_rn      (set_rn),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ports(input int a0, input int a1, input int a2, input int a3);
    r_rn = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic idle_writes();
    w0_en = 1'b0; w1_en = 1'b0; set_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return r_data[k*DW +: DW];
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_writes();
    w0_rn = '0; w1_rn = '0; set_rn = '0; w0_data = '0; w1_data = '0;
    ports(0, 0, 0, 0);
    repeat (2) step();
    check("reset_data", r_data[DW-1:0], 64'h0);
    check("reset_busy", {60'h0, r_busy}, 64'h0);
    check("reset_conflict", {63'h0, wr_conflict}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep r1..r63 across all four ports
    for (int a = 1; a < 64; a += 4) begin
      ports(a, (a + 1 > 63) ? 63 : a + 1, (a + 2 > 63) ? 63 : a + 2, (a + 3 > 63) ? 63 : a + 3);
      step();
      for (int k = 0; k < 4; k++) check("sweep_data", rd(k), 64'h0);
      check("sweep_busy", {60'h0, r_busy}, 64'h0);
    end

    // Write then read next cycle
    w0_en = 1'b1; w0_rn = 6'd5; w0_data = 64'hDEAD_BEEF; ports(0, 0, 0, 0);
    step();
    idle_writes(); ports(5, 0, 0, 0);
    step();
    check("w0_then_read", rd(0), 64'hDEAD_BEEF);

    // Same-edge forwarding on two ports
    w0_en = 1'b1; w0_rn = 6'd7; w0_data = 64'h1234; ports(7, 7, 5, 0);
    step();
    idle_writes();
    check("fwd_p0", rd(0), 64'h1234);
    check("fwd_p1", rd(1), 64'h1234);
    check("fwd_p2_other", rd(2), 64'hDEAD_BEEF);

    // W0/W1 conflict on r9
    w0_en = 1'b1; w0_rn = 6'd9; w0_data = 64'hAAAA;
    w1_en = 1'b1; w1_rn = 6'd9; w1_data = 64'h5555; ports(9, 0, 0, 0);
    step();
    idle_writes();
    check("conflict_fwd_data", rd(0), 64'h5555);
    check("conflict_pulse", {63'h0, wr_conflict}, 64'h1);
    step();
    check("conflict_stored", rd(0), 64'h5555);
    check("conflict_one_cycle", {63'h0, wr_conflict}, 64'h0);

    // Different addresses and both-on-r0 must not flag a conflict
    w0_en = 1'b1; w0_rn = 6'd10; w0_data = 64'h10;
    w1_en = 1'b1; w1_rn = 6'd11; w1_data = 64'h11; ports(10, 11, 0, 0);
    step();
    check("no_conflict_diff", {63'h0, wr_conflict}, 64'h0);
    check("dual_w0", rd(0), 64'h10);
    check("dual_w1", rd(1), 64'h11);
    w0_rn = 6'd0; w1_rn = 6'd0;
    step();
    idle_writes();
    check("no_conflict_r0", {63'h0, wr_conflict}, 64'h0);

    // Scoreboard set / hold / clear / set-wins
    set_en = 1'b1; set_rn = 6'd12; ports(12, 12, 0, 0);
    step();
    idle_writes();
    check("busy_set_fwd", {60'h0, r_busy}, 64'h3);
    step();
    step();
    check("busy_held", {60'h0, r_busy}, 64'h3);
    w0_en = 1'b1; w0_rn = 6'd12; w0_data = 64'h66;
    step();
    idle_writes();
    check("w0_keeps_busy", {60'h0, r_busy}, 64'h3);
    w1_en = 1'b1; w1_rn = 6'd12; w1_data = 64'h77;
    step();
    idle_writes();
    check("w1_clear_data", rd(0), 64'h77);
    check("w1_clear_busy", {60'h0, r_busy}, 64'h0);
    set_en = 1'b1; set_rn = 6'd12;
    w1_en = 1'b1; w1_rn = 6'd12; w1_data = 64'h88;
    step();
    idle_writes();
    check("set_wins_busy", {60'h0, r_busy}, 64'h3);
    check("set_wins_data", rd(0), 64'h88);

    // Register 0 ignores writes and set
    w0_en = 1'b1; w0_rn = 6'd0; w0_data = 64'hFFFF;
    set_en = 1'b1; set_rn = 6'd0; ports(0, 0, 0, 0);
    step();
    idle_writes();
    check("r0_fwd_data", rd(0), 64'h0);
    check("r0_fwd_busy", {60'h0, r_busy}, 64'h0);
    step();
    check("r0_stored", rd(1), 64'h0);

    // Four independent ports: r3/r3/r0/r63, r63 busy
    w0_en = 1'b1; w0_rn = 6'd3; w0_data = 64'h33;
    w1_en = 1'b1; w1_rn = 6'd63; w1_data = 64'h6363;
    step();
    idle_writes();
    set_en = 1'b1; set_rn = 6'd63; ports(3, 3, 0, 63);
    step();
    idle_writes();
    check("p4_port0", rd(0), 64'h33);
    check("p4_port1", rd(1), 64'h33);
    check("p4_port2", rd(2), 64'h0);
    check("p4_port3", rd(3), 64'h6363);
    check("p4_busy", {60'h0, r_busy}, 64'h8);

    // Asynchronous reset mid-cycle with a write to r4 pending
    @(negedge clk);
    w0_en = 1'b1; w0_rn = 6'd4; w0_data = 64'h99; ports(4, 12, 63, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_data", r_data[4*DW-1:0] == '0 ? 64'h0 : 64'h1, 64'h0);
    check("async_busy", {60'h0, r_busy}, 64'h0);
    step();
    check("reset_hold_data", rd(0), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_writes();
    step();
    check("post_reset_r4", rd(0), 64'h0);
    check("post_reset_r63", rd(2), 64'h0);
    check("post_reset_r3", rd(3), 64'h0);
    check("post_reset_busy", {60'h0, r_busy}, 64'h0);
    check("post_reset_conflict", {63'h0, wr_conflict}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
